// File: rtl/thumb_fetch_unit.sv
// Thumb instruction fetch: pulls 32-bit words over req/ack, splits them into two
// 16-bit halfwords for the decoder and drives the register-file PC update strobes.
module thumb_fetch_unit #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_err,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              pc_ld,
    output logic              pc_branch,
    output logic [ADDR_W-1:0] pc_wdata,
    output logic              fetch_fault,
    output logic [2:0]        state_dbg
);

    // Handshakes: memory side holds mem_req/mem_addr until mem_ack and never withdraws
    // a request; decoder side holds instr/instr_addr while instr_valid until instr_ready.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HAVE  = 3'd2,
        S_DROP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [31:0]       buf_q, buf_d;
    logic              hv_lo_q, hv_lo_d;
    logic              hv_hi_q, hv_hi_d;
    logic              skip_lo_q, skip_lo_d;

    logic              mem_req_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              instr_valid_d;
    logic [15:0]       instr_d;
    logic [ADDR_W-1:0] instr_addr_d;
    logic              pc_ld_d;
    logic              pc_branch_d;
    logic [ADDR_W-1:0] pc_wdata_d;
    logic              fetch_fault_d;
    logic              hs;

    assign state_dbg = state_q;
    assign hs        = instr_valid & instr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= RESET_ADDR;
            word_addr_q  <= '0;
            buf_q        <= '0;
            hv_lo_q      <= 1'b0;
            hv_hi_q      <= 1'b0;
            skip_lo_q    <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= RESET_ADDR;
            instr_valid  <= 1'b0;
            instr        <= '0;
            instr_addr   <= '0;
            pc_ld        <= 1'b0;
            pc_branch    <= 1'b0;
            pc_wdata     <= '0;
            fetch_fault  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            word_addr_q  <= word_addr_d;
            buf_q        <= buf_d;
            hv_lo_q      <= hv_lo_d;
            hv_hi_q      <= hv_hi_d;
            skip_lo_q    <= skip_lo_d;
            mem_req      <= mem_req_d;
            mem_addr     <= mem_addr_d;
            instr_valid  <= instr_valid_d;
            instr        <= instr_d;
            instr_addr   <= instr_addr_d;
            pc_ld        <= pc_ld_d;
            pc_branch    <= pc_branch_d;
            pc_wdata     <= pc_wdata_d;
            fetch_fault  <= fetch_fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        word_addr_d   = word_addr_q;
        buf_d         = buf_q;
        hv_lo_d       = hv_lo_q;
        hv_hi_d       = hv_hi_q;
        skip_lo_d     = skip_lo_q;
        pc_ld_d       = 1'b0;
        pc_branch_d   = 1'b0;
        pc_wdata_d    = pc_wdata;
        fetch_fault_d = fetch_fault;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    if (mem_err) begin
                        state_d       = S_FAULT;
                        fetch_fault_d = 1'b1;
                    end else begin
                        buf_d        = mem_rdata;
                        hv_lo_d      = ~skip_lo_q;
                        hv_hi_d      = 1'b1;
                        skip_lo_d    = 1'b0;
                        word_addr_d  = fetch_addr_q;
                        fetch_addr_d = fetch_addr_q + ADDR_W'(4);
                        pc_ld_d      = 1'b1;
                        state_d      = S_HAVE;
                    end
                end
            end
            S_HAVE: begin
                // An empty buffer lingers one cycle in HAVE, giving the bubble before refetch.
                if (!hv_lo_q && !hv_hi_q) begin
                    state_d = S_FETCH;
                end else if (hs) begin
                    if (hv_lo_q) hv_lo_d = 1'b0;
                    else         hv_hi_d = 1'b0;
                end
            end
            S_DROP: begin
                if (mem_ack) state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase

        // A taken branch overrides everything above, including a fill or handshake.
        if (branch_req) begin
            fetch_addr_d  = {branch_target[ADDR_W-1:2], 2'b00};
            skip_lo_d     = branch_target[1];
            hv_lo_d       = 1'b0;
            hv_hi_d       = 1'b0;
            pc_ld_d       = 1'b1;
            pc_branch_d   = 1'b1;
            pc_wdata_d    = {branch_target[ADDR_W-1:1], 1'b0};
            fetch_fault_d = 1'b0;
            if (state_q == S_FETCH || state_q == S_DROP)
                state_d = mem_ack ? S_FETCH : S_DROP;
            else
                state_d = S_FETCH;
        end

        mem_req_d     = (state_d == S_FETCH) || (state_d == S_DROP);
        mem_addr_d    = (state_d == S_FETCH) ? fetch_addr_d : mem_addr;
        instr_valid_d = (state_d == S_HAVE) && (hv_lo_d || hv_hi_d);
        instr_d       = hv_lo_d ? buf_d[15:0] : buf_d[31:16];
        instr_addr_d  = word_addr_d + (hv_lo_d ? ADDR_W'(0) : ADDR_W'(2));
    end

`ifndef SYNTHESIS
    // Once the +4 load has landed, the low half of the word sits four bytes behind the PC.
    always @(posedge clk) begin
        if (rst && state_q == S_HAVE && hv_lo_q && !pc_ld)
            assert (instr_addr == pc_in - ADDR_W'(4))
            else $error("instr_addr %h does not track pc_in %h", instr_addr, pc_in);
    end
`endif

endmodule

// File: tb/tb_thumb_fetch_unit.sv
// Directed bench for thumb_fetch_unit: fill/split, stall, branch in each state,
// bus fault recovery and asynchronous reset.
module tb_thumb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        branch_req;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [31:0] instr_addr;
    logic        pc_ld;
    logic        pc_branch;
    logic [31:0] pc_wdata;
    logic        fetch_fault;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    thumb_fetch_unit #(.ADDR_W(32), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in),
        .branch_req(branch_req), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_addr(instr_addr),
        .pc_ld(pc_ld), .pc_branch(pc_branch), .pc_wdata(pc_wdata),
        .fetch_fault(fetch_fault), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register-file PC, loaded from the strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       pc_in <= 32'h0;
        else if (pc_ld) pc_in <= pc_branch ? pc_wdata : pc_in + 32'd4;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ack_word(input logic [31:0] data, input logic err);
        mem_ack = 1'b1; mem_rdata = data; mem_err = err;
        tick;
        mem_ack = 1'b0; mem_err = 1'b0;
    endtask

    task automatic branch(input logic [31:0] target);
        branch_req = 1'b1; branch_target = target;
        tick;
        branch_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; branch_req = 1'b0; branch_target = '0;
        mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0; instr_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_addr", instr_addr, 0);
        check("rst_pc_ld", pc_ld, 0);
        check("rst_pc_branch", pc_branch, 0);
        check("rst_pc_wdata", pc_wdata, 0);
        check("rst_fault", fetch_fault, 0);
        tick; tick;
        rst = 1'b1;
        check("idle_no_req", mem_req, 0);
        tick;
        check("t1_req", mem_req, 1);
        check("t1_addr", mem_addr, 32'h0);
        tick;
        check("t1_req_wait", mem_req, 1);
        ack_word(32'hBEEF_4770, 1'b0);
        check("t1_valid", instr_valid, 1);
        check("t1_instr_lo", instr, 16'h4770);
        check("t1_addr_lo", instr_addr, 32'h0);
        check("t1_pc_ld", pc_ld, 1);
        check("t1_pc_branch", pc_branch, 0);
        check("t1_req_drop", mem_req, 0);

        // decoder stall
        for (int i = 0; i < 5; i++) begin
            tick;
            check("t2_instr", instr, 16'h4770);
            check("t2_addr", instr_addr, 32'h0);
            check("t2_valid", instr_valid, 1);
            check("t2_no_req", mem_req, 0);
            check("t2_pc_ld", pc_ld, 0);
        end
        instr_ready = 1'b1;
        tick;
        check("t1_instr_hi", instr, 16'hBEEF);
        check("t1_addr_hi", instr_addr, 32'h2);
        check("t1_valid_hi", instr_valid, 1);
        check("t2_no_req_hi", mem_req, 0);
        tick;
        instr_ready = 1'b0;
        check("t1_empty", instr_valid, 0);
        check("t1_bubble", mem_req, 0);
        tick;
        check("t1_next_req", mem_req, 1);
        check("t1_next_addr", mem_addr, 32'h4);
        check("t1_pc", pc_in, 32'h4);

        // branch from HAVE to an odd halfword
        ack_word(32'h1111_2222, 1'b0);
        check("t3_pre_instr", instr, 16'h2222);
        check("t3_pre_addr", instr_addr, 32'h4);
        tick;
        check("t3_pre_pc_ld", pc_ld, 0);
        branch(32'h0000_0102);
        check("t3_flush", instr_valid, 0);
        check("t3_pc_ld", pc_ld, 1);
        check("t3_pc_branch", pc_branch, 1);
        check("t3_pc_wdata", pc_wdata, 32'h102);
        check("t3_req", mem_req, 1);
        check("t3_addr", mem_addr, 32'h100);
        tick;
        check("t3_pc_ld_fall", pc_ld, 0);
        check("t3_pc_branch_fall", pc_branch, 0);
        ack_word(32'hCAFE_D00D, 1'b0);
        check("t3_instr", instr, 16'hCAFE);
        check("t3_instr_addr", instr_addr, 32'h102);
        check("t3_valid", instr_valid, 1);
        check("t3_fill_pc_ld", pc_ld, 1);
        check("t3_fill_pc_branch", pc_branch, 0);
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        check("t3_empty", instr_valid, 0);
        tick;
        check("t3_next_req", mem_req, 1);
        check("t3_next_addr", mem_addr, 32'h104);

        // branch in FETCH, the outstanding ack comes 3 cycles later
        branch(32'h0000_0200);
        check("t4_req_held", mem_req, 1);
        check("t4_addr_held", mem_addr, 32'h104);
        check("t4_pc_ld", pc_ld, 1);
        check("t4_pc_branch", pc_branch, 1);
        check("t4_pc_wdata", pc_wdata, 32'h200);
        tick;
        check("t4_drop_addr", mem_addr, 32'h104);
        check("t4_drop_pc_ld", pc_ld, 0);
        tick;
        ack_word(32'hDEAD_BEEF, 1'b0);
        check("t4_discard_valid", instr_valid, 0);
        check("t4_discard_pc_ld", pc_ld, 0);
        check("t4_req", mem_req, 1);
        check("t4_addr", mem_addr, 32'h200);
        check("t4_pc", pc_in, 32'h200);
        tick;
        check("t4_still_empty", instr_valid, 0);
        ack_word(32'h4444_3333, 1'b0);
        check("t4_instr_lo", instr, 16'h3333);
        check("t4_addr_lo", instr_addr, 32'h200);
        instr_ready = 1'b1;
        tick;
        check("t4_instr_hi", instr, 16'h4444);
        check("t4_addr_hi", instr_addr, 32'h202);
        tick;
        instr_ready = 1'b0;
        check("t4_empty", instr_valid, 0);
        tick;
        check("t4_next_addr", mem_addr, 32'h204);

        // branch together with mem_ack
        branch_req = 1'b1; branch_target = 32'h0000_0300;
        ack_word(32'h5555_6666, 1'b0);
        branch_req = 1'b0;
        check("t5_discard_valid", instr_valid, 0);
        check("t5_pc_ld", pc_ld, 1);
        check("t5_pc_branch", pc_branch, 1);
        check("t5_pc_wdata", pc_wdata, 32'h300);
        check("t5_req", mem_req, 1);
        check("t5_addr", mem_addr, 32'h300);
        tick;
        check("t5_single_pc_ld", pc_ld, 0);
        check("t5_still_empty", instr_valid, 0);
        ack_word(32'h7777_8888, 1'b0);
        check("t5_instr", instr, 16'h8888);
        check("t5_instr_addr", instr_addr, 32'h300);
        check("t5_fill_branch", pc_branch, 0);
        tick;
        check("t5_pc", pc_in, 32'h304);

        // bus fault and recovery
        branch(32'h0000_0008);
        check("t6_addr", mem_addr, 32'h8);
        check("t6_req", mem_req, 1);
        ack_word(32'h0, 1'b1);
        check("t6_fault", fetch_fault, 1);
        check("t6_no_req", mem_req, 0);
        check("t6_no_valid", instr_valid, 0);
        check("t6_no_pc_ld", pc_ld, 0);
        tick; tick;
        check("t6_fault_sticky", fetch_fault, 1);
        check("t6_still_no_req", mem_req, 0);
        branch(32'h0000_0000);
        check("t6_fault_clr", fetch_fault, 0);
        check("t6_refetch", mem_req, 1);
        check("t6_refetch_addr", mem_addr, 32'h0);
        check("t6_pc_branch", pc_branch, 1);
        tick;
        ack_word(32'h1234_BF00, 1'b0);
        check("t6_instr", instr, 16'hBF00);
        check("t6_instr_addr", instr_addr, 32'h0);
        instr_ready = 1'b1;
        tick;
        check("t6_instr_hi", instr, 16'h1234);
        tick;
        instr_ready = 1'b0;
        tick;
        check("t6_fetch4", mem_addr, 32'h4);

        // asynchronous reset mid-FETCH
        #2 rst = 1'b0;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_addr", mem_addr, 32'h0);
        check("arst_instr", instr, 0);
        check("arst_instr_addr", instr_addr, 0);
        check("arst_valid", instr_valid, 0);
        check("arst_pc_ld", pc_ld, 0);
        check("arst_state", state_dbg, 0);
        tick;
        rst = 1'b1;
        tick;
        check("arst_restart_req", mem_req, 1);
        check("arst_restart_addr", mem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
